// File: rtl/cla_seq_adder.sv
// Byte-serial WIDTH-bit add/subtract: one 8-bit carry-lookahead slice is reused once per clock,
// least-significant byte first, behind valid/ready request and result handshakes.

module CLA_Adder (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       c_i,
  output logic [7:0] s_o,
  output logic       c_o,
  output logic       g_o,
  output logic       p_o
);
  logic [7:0] gen_s;
  logic [7:0] prop_s;
  logic [8:0] carry_s;

  assign gen_s  = a_i & b_i;
  assign prop_s = a_i ^ b_i;

  // Each carry is a flat sum of generate/propagate products, not a ripple chain.
  always_comb begin
    logic term_v;
    term_v  = 1'b0;
    carry_s = 9'd0;
    carry_s[0] = c_i;
    for (int i = 0; i < 8; i++) begin
      term_v = c_i;
      for (int j = 0; j <= i; j++) begin
        term_v = term_v & prop_s[j];
      end
      carry_s[i+1] = term_v;
      for (int k = 0; k <= i; k++) begin
        term_v = gen_s[k];
        for (int j = k + 1; j <= i; j++) begin
          term_v = term_v & prop_s[j];
        end
        carry_s[i+1] = carry_s[i+1] | term_v;
      end
    end
  end

  // Group generate for cascading slices in a two-level lookahead.
  always_comb begin
    logic grp_v;
    grp_v = 1'b0;
    g_o   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      grp_v = gen_s[k];
      for (int j = k + 1; j < 8; j++) begin
        grp_v = grp_v & prop_s[j];
      end
      g_o = g_o | grp_v;
    end
  end

  assign p_o = &prop_s;
  assign s_o = prop_s ^ carry_s[7:0];
  assign c_o = carry_s[8];
endmodule

module cla_seq_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int BEATS = WIDTH / 8;
  localparam int BW    = $clog2(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  if ((WIDTH % 8) != 0 || WIDTH < 16) begin : g_bad_width
    $error("cla_seq_adder: WIDTH must be a multiple of 8 and at least 16");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [7:0]       slice_a_s;
  logic [7:0]       slice_b_s;
  logic [7:0]       slice_sum_s;
  logic             slice_cout_s;
  logic             slice_g_unused;
  logic             slice_p_unused;
  logic             last_beat_s;

  assign slice_a_s   = opa_q[{beat_q, 3'b000} +: 8];
  assign slice_b_s   = opb_q[{beat_q, 3'b000} +: 8];
  assign last_beat_s = (beat_q == LAST_BEAT);

  CLA_Adder u_slice (
    .a_i (slice_a_s),
    .b_i (slice_b_s),
    .c_i (carry_q),
    .s_o (slice_sum_s),
    .c_o (slice_cout_s),
    .g_o (slice_g_unused),
    .p_o (slice_p_unused)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; DONE always returns to IDLE so no accept overlaps a hand-off.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_beat_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state register.
  always_comb begin
    start_ready = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b0;
    case (state_q)
      ST_IDLE: start_ready = 1'b1;
      ST_RUN:  busy        = 1'b1;
      ST_DONE: begin
        res_valid = 1'b1;
        busy      = 1'b1;
      end
      default: start_ready = 1'b0;
    endcase
  end

  // Datapath next state: subtract is folded into A + ~B + 1 at acceptance.
  always_comb begin
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    beat_d  = beat_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          sum_d   = {WIDTH{1'b0}};
          beat_d  = {BW{1'b0}};
        end else begin
          opa_d = opa_q;
        end
      end
      ST_RUN: begin
        sum_d[{beat_q, 3'b000} +: 8] = slice_sum_s;
        carry_d = slice_cout_s;
        if (last_beat_s) begin
          cout_d = slice_cout_s;
          ovf_d  = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) && (slice_sum_s[7] != opa_q[WIDTH-1]);
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      ST_DONE: begin
        sum_d = sum_q;
      end
      default: begin
        sum_d = sum_q;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_q   <= {WIDTH{1'b0}};
      opb_q   <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      beat_q  <= {BW{1'b0}};
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      beat_q  <= beat_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule
